word_break_sched: RTL
=====================

// Module: word_break_sched
// PURPOSE
//   Round-robin scheduler that shares one word-breaking datapath among N_SRC requesters.
//   - Each requester offers a WORD_IN_SIZE word through a valid/ready handshake.
//   - The granted word is captured and emitted MSB slice first, one WORD_OUT_SIZE slice per
//     accepted beat, tagged with source id and a last flag.
//   - Sits between the wide producer ports and the narrow byte-stream consumer.
// PARAMETERS
//   WORD_IN_SIZE   32  width of each requester word; must be a multiple of WORD_OUT_SIZE
//   WORD_OUT_SIZE  8   width of each output slice
//   N_SRC          4   number of requesters, >= 2
//   derived: NSLICE = WORD_IN_SIZE/WORD_OUT_SIZE (>= 2); SW = $clog2(N_SRC)
// PORTS
//   clock      in   1                    single clock; all logic on posedge
//   reset      in   1                    synchronous reset, active-low (0 = reset)
//   src_valid  in   N_SRC                per-requester word valid
//   src_data   in   N_SRC*WORD_IN_SIZE   requester i word at [i*WORD_IN_SIZE +: WORD_IN_SIZE]
//   src_ready  out  N_SRC                one-hot grant/accept; word i taken when valid&ready
//   out_valid  out  1                    word_out holds a valid slice
//   out_ready  in   1                    consumer accepts the slice this cycle
//   word_out   out  WORD_OUT_SIZE        current slice
//   out_src    out  SW                   index of the source owning the current word
//   out_last   out  1                    current slice is the final (LSB) slice of the word
//   busy       out  1                    1 while in SEND
// BEHAVIOUR
//   - Reset (reset==0 at posedge):
//     - state=IDLE, rr_ptr=0, idx=0, data reg=0, grant=0.
//     - Outputs: src_ready=0, out_valid=0, word_out=0, out_src=0, out_last=0, busy=0.
//     - Overrides all other activity; a partially sent word is discarded, never resumed.
//   - FSM state IDLE:
//     - out_valid=0.
//     - If any src_valid, winner = first i with src_valid[i], searching rr_ptr, rr_ptr+1, ...
//       modulo N_SRC.
//     - src_ready = one-hot(winner), combinational from src_valid and rr_ptr; all zero if no
//       src_valid.
//     - On that posedge: data reg <= src_data[winner], grant <= winner, idx <= 0, go to SEND.
//   - FSM state SEND:
//     - src_ready=0, out_valid=1, busy=1, out_src=grant.
//     - word_out = data reg slice NSLICE-1-idx; idx 0 is bits [WIDTH-1 -: WORD_OUT_SIZE].
//     - out_last = (idx == NSLICE-1).
//     - out_ready=0: hold word_out/out_src/out_last stable, no state change.
//     - out_ready=1 and not last: idx <= idx+1.
//     - out_ready=1 and last: go to IDLE; rr_ptr <= (grant+1) mod N_SRC.
//   - Timing:
//     - src_ready to first slice: 1 cycle.
//     - Full word: NSLICE+1 cycles minimum, one IDLE bubble per word.
//   - Requester rules:
//     - src_valid may drop at any time before grant with no effect.
//     - src_data is sampled only on the grant cycle.
//   - Fairness: rr_ptr advances only on word completion.
//     - With all requesters continuously valid, grants rotate 0,1,..,N_SRC-1,0.
//   - idx and rr_ptr wrap modulo NSLICE / N_SRC. Non-power-of-two N_SRC must wrap to 0, not
//     to 2**SW.
// TESTING
//   1. reset=0 for 3 cycles, all src_valid=1 -> src_ready=0, out_valid=0, word_out=0, busy=0
//      every cycle.
//   2. Reset released, src_valid=0001, src_data[0]=0xA1B2C3D4, out_ready=1:
//      - src_ready=0001 for exactly one cycle.
//      - Next 4 cycles word_out=A1,B2,C3,D4 with out_src=0; out_last only on D4.
//   3. All src_valid=1111 continuously, out_ready=1 -> grants 0,1,2,3,0, each 5 cycles apart.
//   4. out_ready=0 for 3 cycles while word_out=B2 -> B2, out_valid=1, out_last=0 held;
//      C3 follows on the first cycle out_ready=1.
//   5. reset=0 after A1,B2 accepted -> next cycle all outputs 0, rr_ptr=0.
//      - On release with src_valid[0]=1 the word restarts from A1.
//   6. rr_ptr=1, src_valid=0101 -> source 2 granted first, then source 0; source 1 never granted.

Source files
------------

// File: rtl/word_break_sched.sv
// word_break_sched: round-robin arbiter feeding one wide-word-to-slice serializer
module word_break_sched #(
  parameter int WORD_IN_SIZE  = 32,
  parameter int WORD_OUT_SIZE = 8,
  parameter int N_SRC         = 4,
  localparam int NSLICE = WORD_IN_SIZE / WORD_OUT_SIZE,
  localparam int SW     = $clog2(N_SRC),
  localparam int IW     = $clog2(NSLICE)
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [N_SRC-1:0]              i_src_valid,
  input  logic [N_SRC*WORD_IN_SIZE-1:0] i_src_data,
  output logic [N_SRC-1:0]              o_src_ready,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic [WORD_OUT_SIZE-1:0]      o_word_out,
  output logic [SW-1:0]                 o_out_src,
  output logic                          o_out_last,
  output logic                          o_busy
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t                  r_state;
  logic [SW-1:0]           r_rr_ptr;
  logic [SW-1:0]           r_grant;
  logic [IW-1:0]           r_idx;
  logic [WORD_IN_SIZE-1:0] r_data;
  logic                    w_any;
  logic                    w_last;
  logic                    w_send;
  logic [SW-1:0]           w_win;
  logic [WORD_OUT_SIZE-1:0] w_slice;
  // Scan downward so the candidate closest to rr_ptr is written last and wins.
  always_comb begin
    w_win = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      int j;
      j = (int'(r_rr_ptr) + k) % N_SRC;
      if (i_src_valid[j]) w_win = SW'(j);
    end
  end
  assign w_any   = |i_src_valid;
  assign w_send  = r_state == SEND;
  assign w_last  = r_idx == IW'(NSLICE - 1);
  assign w_slice = r_data[WORD_IN_SIZE-1-int'(r_idx)*WORD_OUT_SIZE -: WORD_OUT_SIZE];
  // Grant is suppressed while reset is asserted so no word looks accepted.
  assign o_src_ready = (!w_send && i_reset && w_any) ? N_SRC'(1) << w_win : '0;
  assign o_out_valid = w_send;
  assign o_busy      = w_send;
  assign o_word_out  = w_send ? w_slice : '0;
  assign o_out_src   = w_send ? r_grant : '0;
  assign o_out_last  = w_send && w_last;
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_idx    <= '0;
      r_data   <= '0;
    end else if (!w_send) begin
      if (w_any) begin
        r_data  <= i_src_data[int'(w_win)*WORD_IN_SIZE +: WORD_IN_SIZE];
        r_grant <= w_win;
        r_idx   <= '0;
        r_state <= SEND;
      end
    end else if (i_out_ready) begin
      if (w_last) begin
        r_state  <= IDLE;
        r_rr_ptr <= (r_grant == SW'(N_SRC - 1)) ? '0 : r_grant + 1'b1;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end
endmodule
